// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift schedule,
// FSM state type and the PC-1 helper used at key load.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Tables use DES numbering: entry values are 1-based source bit numbers.
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // DES bit n lives at key[64-n]; CD bit n lives at cd[56-n].
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
    end
    return cd;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit C/D register to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 on load, per-round C/D rotation, PC-2 per subkey.
// Emits K1..K16 (or K16..K1 when decrypting) over a valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  output logic [47:0] key_dat,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  state_t      state_q, state_d;
  logic [55:0] cd_q;
  logic [55:0] cd_load;
  logic [3:0]  round_q;
  logic        mode_q;
  logic        done_q;
  logic        parity_q;
  logic [47:0] subkey;
  logic [7:0]  byte_odd;
  logic        parity_bad;
  logic        accept;
  logic        last_round;
  logic        enc_two;
  logic        dec_two;

  function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
    return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] h, input logic two);
    return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  for (genvar g = 0; g < 8; g++) begin : g_parity
    assign byte_odd[g] = ^key_in[8*g +: 8];
  end

  assign parity_bad = ~&byte_odd;
  assign cd_load    = pc1(key_in);
  assign accept     = (state_q == RUN) && key_ready;
  assign last_round = (round_q == 4'd15);

  // Encrypt rotates by the shift of the next round; decrypt undoes the shift
  // of the round just emitted, walking the schedule backwards.
  assign enc_two = (SHIFT_TABLE[round_q + 4'd1] == 2);
  assign dec_two = (SHIFT_TABLE[4'd15 - round_q] == 2);

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_load) state_d = RUN;
      RUN:  if (accept && last_round) state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    key_valid = 1'b0;
    key_dat   = '0;
    if (state_q == RUN) begin
      busy      = 1'b1;
      key_valid = 1'b1;
      key_dat   = subkey;
    end
  end

  // Decrypt starts from CD16, which equals CD0 since the rotations total 28.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q     <= '0;
      round_q  <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (key_load) begin
          mode_q   <= decrypt;
          round_q  <= '0;
          parity_q <= (PARITY_CHECK != 0) && parity_bad;
          if (decrypt) cd_q <= cd_load;
          else cd_q <= {rotl28(cd_load[55:28], SHIFT_TABLE[0] == 2),
                        rotl28(cd_load[27:0],  SHIFT_TABLE[0] == 2)};
        end
      end else if (accept) begin
        if (last_round) begin
          round_q <= '0;
          done_q  <= 1'b1;
        end else begin
          round_q <= round_q + 4'd1;
          if (mode_q) cd_q <= {rotr28(cd_q[55:28], dec_two), rotr28(cd_q[27:0], dec_two)};
          else        cd_q <= {rotl28(cd_q[55:28], enc_two), rotl28(cd_q[27:0], enc_two)};
        end
      end
    end
  end

  assign round_idx  = round_q;
  assign done       = done_q;
  assign parity_err = parity_q;

endmodule
